conv_kernel_ctrl: RTL and testbench

- Configuration controller for convolution_2d_filter. Owns the nine signed 3x3 kernel coefficients that drive the filter's k11..k33 inputs.
- Selects among hard-coded preset kernels, or a custom kernel loaded serially.
- Defers every kernel change to a frame boundary, the accepted start-of-packet beat on the video stream, so no frame is filtered with a mix of two kernels.
- Sits beside the filter in the VGA pipeline. Driven by board keys/switches or a host register port.

---
 rtl/conv_kernel_pkg.sv | 47 ++++
 rtl/key_edge_detect.sv | 19 +
 rtl/conv_kernel_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_conv_kernel_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_kernel_pkg.sv
// Shared types and the preset kernel ROM for the convolution kernel controller.
package conv_kernel_pkg;

  localparam int NUM_COEF  = 9;
  localparam int ROM_DEPTH = 6;

  typedef logic signed [7:0] coef_t;

  // Element 0 is k11, element 8 is k33 (row-major).
  typedef coef_t [0:NUM_COEF-1] kernel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ARMED = 2'd2
  } ctrl_state_t;

  localparam kernel_t KERNEL_PRESETS [0:ROM_DEPTH-1] = '{
    // identity
    '{ 8'sd0,  8'sd0,  8'sd0,  8'sd0,  8'sd1,  8'sd0,  8'sd0,  8'sd0,  8'sd0},
    // box
    '{ 8'sd1,  8'sd1,  8'sd1,  8'sd1,  8'sd1,  8'sd1,  8'sd1,  8'sd1,  8'sd1},
    // sharpen
    '{ 8'sd0, -8'sd1,  8'sd0, -8'sd1,  8'sd5, -8'sd1,  8'sd0, -8'sd1,  8'sd0},
    // edge
    '{-8'sd1, -8'sd1, -8'sd1, -8'sd1,  8'sd8, -8'sd1, -8'sd1, -8'sd1, -8'sd1},
    // gaussian
    '{ 8'sd1,  8'sd2,  8'sd1,  8'sd2,  8'sd4,  8'sd2,  8'sd1,  8'sd2,  8'sd1},
    // emboss
    '{-8'sd2, -8'sd1,  8'sd0, -8'sd1,  8'sd1,  8'sd1,  8'sd0,  8'sd1,  8'sd2}
  };

  // Out-of-range indices fall back to identity.
  function automatic kernel_t preset_kernel(input logic [2:0] idx);
    kernel_t k;
    case (idx)
      3'd1:    k = KERNEL_PRESETS[1];
      3'd2:    k = KERNEL_PRESETS[2];
      3'd3:    k = KERNEL_PRESETS[3];
      3'd4:    k = KERNEL_PRESETS[4];
      3'd5:    k = KERNEL_PRESETS[5];
      default: k = KERNEL_PRESETS[0];
    endcase
    return k;
  endfunction

endpackage

// File: rtl/key_edge_detect.sv
// Rising-edge detector for an already debounced, synchronous key level.
module key_edge_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_i,
  output logic rise_o
);

  logic key_q;

  // Remember the previous key level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) key_q <= 1'b0;
    else         key_q <= key_i;
  end

  assign rise_o = key_i & ~key_q;

endmodule

// File: rtl/conv_kernel_ctrl.sv
// Kernel coefficient controller for the 2-D convolution filter.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | active kernel stable, no change requested
//   LOAD  | custom coefficients being written into staging
//   ARMED | target kernel chosen, waiting for the next frame boundary
//
// Kernel changes only land on the accepted start-of-packet beat so a frame
// is never filtered with a mix of two kernels.
module conv_kernel_ctrl
  import conv_kernel_pkg::*;
#(
  parameter int NUM_PRESETS = 6,
  parameter int CUSTOM_IDX  = 6
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       key_next_i,
  input  logic       sel_valid_i,
  input  logic [2:0] sel_idx_i,
  input  logic       cfg_wr_valid_i,
  output logic       cfg_wr_ready_o,
  input  logic [7:0] cfg_wr_data_i,
  input  logic       cfg_commit_i,
  input  logic       sop_in_i,
  input  logic       valid_in_i,
  input  logic       ready_in_i,
  output logic [7:0] k11_o,
  output logic [7:0] k12_o,
  output logic [7:0] k13_o,
  output logic [7:0] k21_o,
  output logic [7:0] k22_o,
  output logic [7:0] k23_o,
  output logic [7:0] k31_o,
  output logic [7:0] k32_o,
  output logic [7:0] k33_o,
  output logic [2:0] kernel_id_o,
  output logic       pending_o,
  output logic       applied_o
);

  localparam logic [2:0] CUSTOM_ID   = 3'(CUSTOM_IDX);
  localparam logic [2:0] LAST_PRESET = 3'(NUM_PRESETS - 1);
  localparam logic [3:0] FULL_COUNT  = 4'(NUM_COEF);

  ctrl_state_t state_q, state_d;
  logic [2:0]  target_q, target_d;
  logic [3:0]  count_q, count_d;
  logic [2:0]  kernel_id_q;
  kernel_t     staging_q;
  kernel_t     active_q;
  logic        applied_q;

  logic        key_rise;
  logic        boundary;
  logic        req_valid;
  logic        wr_fire;
  logic        stage_we;
  logic        apply;
  logic [2:0]  sel_target;
  logic [2:0]  key_base;
  logic [2:0]  key_target;
  logic [2:0]  req_target;

  key_edge_detect u_key_edge (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .key_i  (key_next_i),
    .rise_o (key_rise)
  );

  assign boundary       = sop_in_i & valid_in_i & ready_in_i;
  assign cfg_wr_ready_o = (state_q == IDLE) |
                          ((state_q == LOAD) & (count_q < FULL_COUNT));
  assign wr_fire        = cfg_wr_valid_i & cfg_wr_ready_o;
  assign req_valid      = sel_valid_i | key_rise;

  // Resolve which kernel a select or key request points at.
  always_comb begin
    sel_target = (sel_idx_i <= LAST_PRESET) ? sel_idx_i : 3'd0;
    // While armed the key steps from the pending target, otherwise from the active kernel.
    key_base   = (state_q == ARMED) ? target_q : kernel_id_q;
    // Wraps after the last preset and also leaves the custom kernel back to preset 0.
    if (key_base >= LAST_PRESET) key_target = 3'd0;
    else                         key_target = key_base + 3'd1;
    req_target = sel_valid_i ? sel_target : key_target;
  end

  // Next-state logic: requests beat configuration writes and commits.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    count_d  = count_q;
    stage_we = 1'b0;
    apply    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          target_d = req_target;
          state_d  = ARMED;
        end else if (wr_fire) begin
          stage_we = 1'b1;
          count_d  = 4'd1;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        if (req_valid) begin
          target_d = req_target;
          count_d  = 4'd0;
          state_d  = ARMED;
        end else if (cfg_commit_i && (count_q == FULL_COUNT)) begin
          target_d = CUSTOM_ID;
          count_d  = 4'd0;
          state_d  = ARMED;
        end else if (wr_fire) begin
          stage_we = 1'b1;
          count_d  = count_q + 4'd1;
        end
      end
      ARMED: begin
        if (boundary) begin
          apply   = 1'b1;
          state_d = req_valid ? ARMED : IDLE;
        end
        if (req_valid) target_d = req_target;
      end
      default: begin
        state_d = IDLE;
        count_d = 4'd0;
      end
    endcase
  end

  // FSM, target and load-count registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      target_q <= 3'd0;
      count_q  <= 4'd0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      count_q  <= count_d;
    end
  end

  // Custom coefficient staging, filled in row-major order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)       staging_q          <= '0;
    else if (stage_we) staging_q[count_q] <= cfg_wr_data_i;
  end

  // Active kernel only moves on the frame-boundary edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      active_q    <= KERNEL_PRESETS[0];
      kernel_id_q <= 3'd0;
      applied_q   <= 1'b0;
    end else begin
      applied_q <= apply;
      if (apply) begin
        active_q    <= (target_q == CUSTOM_ID) ? staging_q : preset_kernel(target_q);
        kernel_id_q <= target_q;
      end
    end
  end

  assign k11_o       = active_q[0];
  assign k12_o       = active_q[1];
  assign k13_o       = active_q[2];
  assign k21_o       = active_q[3];
  assign k22_o       = active_q[4];
  assign k23_o       = active_q[5];
  assign k31_o       = active_q[6];
  assign k32_o       = active_q[7];
  assign k33_o       = active_q[8];
  assign kernel_id_o = kernel_id_q;
  assign pending_o   = (state_q == ARMED);
  assign applied_o   = applied_q;

endmodule

// File: tb/tb_conv_kernel_ctrl.sv
// Self-checking bench for conv_kernel_ctrl: directed scenarios then random traffic,
// compared every cycle against a request/queue level reference model.
module tb_conv_kernel_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       key_next_i = 1'b0;
  logic       sel_valid_i = 1'b0;
  logic [2:0] sel_idx_i = 3'd0;
  logic       cfg_wr_valid_i = 1'b0;
  logic       cfg_wr_ready_o;
  logic [7:0] cfg_wr_data_i = 8'd0;
  logic       cfg_commit_i = 1'b0;
  logic       sop_in_i = 1'b0;
  logic       valid_in_i = 1'b0;
  logic       ready_in_i = 1'b0;
  logic [7:0] k11_o, k12_o, k13_o, k21_o, k22_o, k23_o, k31_o, k32_o, k33_o;
  logic [2:0] kernel_id_o;
  logic       pending_o;
  logic       applied_o;

  always #5 clk_i = ~clk_i;

  conv_kernel_ctrl #(.NUM_PRESETS(6), .CUSTOM_IDX(6)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .key_next_i     (key_next_i),
    .sel_valid_i    (sel_valid_i),
    .sel_idx_i      (sel_idx_i),
    .cfg_wr_valid_i (cfg_wr_valid_i),
    .cfg_wr_ready_o (cfg_wr_ready_o),
    .cfg_wr_data_i  (cfg_wr_data_i),
    .cfg_commit_i   (cfg_commit_i),
    .sop_in_i       (sop_in_i),
    .valid_in_i     (valid_in_i),
    .ready_in_i     (ready_in_i),
    .k11_o          (k11_o),
    .k12_o          (k12_o),
    .k13_o          (k13_o),
    .k21_o          (k21_o),
    .k22_o          (k22_o),
    .k23_o          (k23_o),
    .k31_o          (k31_o),
    .k32_o          (k32_o),
    .k33_o          (k33_o),
    .kernel_id_o    (kernel_id_o),
    .pending_o      (pending_o),
    .applied_o      (applied_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: active kernel, an optional pending target, and the list of
  // custom coefficients written so far.
  int presets [6][9] = '{
    '{ 0,  0,  0,  0, 1,  0,  0,  0,  0},
    '{ 1,  1,  1,  1, 1,  1,  1,  1,  1},
    '{ 0, -1,  0, -1, 5, -1,  0, -1,  0},
    '{-1, -1, -1, -1, 8, -1, -1, -1, -1},
    '{ 1,  2,  1,  2, 4,  2,  1,  2,  1},
    '{-2, -1,  0, -1, 1,  1,  0,  1,  2}
  };
  int m_active [9];
  int m_custom [9];
  int m_stage [$];
  int m_id;
  int m_target;
  bit m_armed;
  bit m_applied;
  bit m_key_prev;

  task automatic model_reset();
    for (int i = 0; i < 9; i++) m_active[i] = presets[0][i];
    m_stage.delete();
    m_id = 0;
    m_target = 0;
    m_armed = 0;
    m_applied = 0;
    m_key_prev = 0;
  endtask

  task automatic model_step();
    bit rise, bnd, rdy, was_armed, req;
    int tgt_new, base;
    rise = key_next_i && !m_key_prev;
    m_key_prev = key_next_i;
    bnd = sop_in_i && valid_in_i && ready_in_i;
    was_armed = m_armed;
    rdy = !m_armed && (m_stage.size() < 9);
    req = sel_valid_i || rise;
    if (sel_valid_i) tgt_new = (sel_idx_i < 6) ? int'(sel_idx_i) : 0;
    else begin
      base = m_armed ? m_target : m_id;
      tgt_new = (base >= 6) ? 0 : (base + 1) % 6;
    end
    m_applied = 0;
    if (was_armed && bnd) begin
      for (int i = 0; i < 9; i++)
        m_active[i] = (m_target == 6) ? m_custom[i] : presets[m_target][i];
      m_id = m_target;
      m_applied = 1;
      m_armed = 0;
    end
    if (req) begin
      m_target = tgt_new;
      m_armed = 1;
      m_stage.delete();
    end else if (!was_armed) begin
      if (cfg_wr_valid_i && rdy) m_stage.push_back(int'($signed(cfg_wr_data_i)));
      else if (cfg_commit_i && m_stage.size() == 9) begin
        for (int i = 0; i < 9; i++) m_custom[i] = m_stage[i];
        m_target = 6;
        m_armed = 1;
        m_stage.delete();
      end
    end
  endtask

  function automatic logic [71:0] dut_coefs();
    return {k11_o, k12_o, k13_o, k21_o, k22_o, k23_o, k31_o, k32_o, k33_o};
  endfunction

  function automatic logic [71:0] model_coefs();
    logic [71:0] v;
    for (int i = 0; i < 9; i++) v[71-8*i -: 8] = 8'(m_active[i]);
    return v;
  endfunction

  task automatic check_all();
    check("coefs", dut_coefs(), model_coefs());
    check("kernel_id", 72'(kernel_id_o), 72'(m_id));
    check("pending", 72'(pending_o), 72'(m_armed));
    check("applied", 72'(applied_o), 72'(m_applied));
    check("wr_ready", 72'(cfg_wr_ready_o), 72'(!m_armed && m_stage.size() < 9));
  endtask

  task automatic step();
    @(posedge clk_i);
    model_step();
    #1;
    check_all();
  endtask

  task automatic quiet();
    sel_valid_i = 0; cfg_wr_valid_i = 0; cfg_commit_i = 0;
    sop_in_i = 0; valid_in_i = 0; ready_in_i = 0;
  endtask

  task automatic do_sel(input logic [2:0] idx);
    sel_valid_i = 1; sel_idx_i = idx; step(); quiet();
  endtask

  task automatic do_boundary();
    sop_in_i = 1; valid_in_i = 1; ready_in_i = 1; step(); quiet();
  endtask

  task automatic do_key();
    key_next_i = 1; step(); key_next_i = 0; step();
  endtask

  task automatic do_write(input logic [7:0] d);
    cfg_wr_valid_i = 1; cfg_wr_data_i = d; step(); quiet();
  endtask

  localparam logic [71:0] K_IDENT   = {8'h00,8'h00,8'h00,8'h00,8'h01,8'h00,8'h00,8'h00,8'h00};
  localparam logic [71:0] K_BOX     = {8'h01,8'h01,8'h01,8'h01,8'h01,8'h01,8'h01,8'h01,8'h01};
  localparam logic [71:0] K_SHARPEN = {8'h00,8'hFF,8'h00,8'hFF,8'h05,8'hFF,8'h00,8'hFF,8'h00};
  localparam logic [71:0] K_EDGE    = {8'hFF,8'hFF,8'hFF,8'hFF,8'h08,8'hFF,8'hFF,8'hFF,8'hFF};
  localparam logic [71:0] K_EMBOSS  = {8'hFE,8'hFF,8'h00,8'hFF,8'h01,8'h01,8'h00,8'h01,8'h02};
  localparam logic [71:0] K_CUSTOM  = {8'hFF,8'h02,8'hFD,8'h04,8'hFB,8'h06,8'hF9,8'h08,8'hF7};

  initial begin
    int cust [9] = '{-1, 2, -3, 4, -5, 6, -7, 8, -9};
    model_reset();
    quiet();
    repeat (2) @(posedge clk_i);
    #1;
    check_all();
    check("rst_coefs", dut_coefs(), K_IDENT);
    @(negedge clk_i);
    rst_ni = 1;
    step();
    check("rst_ready", 72'(cfg_wr_ready_o), 72'(1));

    // Select sharpen, hold the SOP beat back with ready low.
    do_sel(3'd2);
    sop_in_i = 1; valid_in_i = 1; ready_in_i = 0;
    repeat (5) step();
    check("hold_coefs", dut_coefs(), K_IDENT);
    ready_in_i = 1; step(); quiet();
    check("sharpen", dut_coefs(), K_SHARPEN);
    check("sharpen_id", 72'(kernel_id_o), 72'(2));
    step();

    // Three key presses from gaussian: 4 -> 5 -> 0 -> 1.
    do_sel(3'd4); do_boundary(); step();
    do_key(); do_key(); do_key();
    do_boundary();
    check("key_id", 72'(kernel_id_o), 72'(1));
    check("key_box", dut_coefs(), K_BOX);
    step();

    // Full custom load, a refused 10th write, then commit and apply.
    for (int i = 0; i < 9; i++) do_write(8'(cust[i]));
    check("full_ready", 72'(cfg_wr_ready_o), 72'(0));
    do_write(8'h55);
    cfg_commit_i = 1; step(); quiet();
    do_boundary();
    check("custom", dut_coefs(), K_CUSTOM);
    check("custom_id", 72'(kernel_id_o), 72'(6));
    step();

    // Short load, ignored commit, then a select aborts it.
    for (int i = 0; i < 5; i++) do_write(8'(i + 10));
    cfg_commit_i = 1; step(); quiet();
    check("short_commit", 72'(pending_o), 72'(0));
    do_sel(3'd3);
    do_boundary();
    check("edge", dut_coefs(), K_EDGE);
    step();

    // New request on the boundary cycle becomes the next target.
    do_sel(3'd1);
    sel_valid_i = 1; sel_idx_i = 3'd5;
    sop_in_i = 1; valid_in_i = 1; ready_in_i = 1;
    step(); quiet();
    check("back2back_box", dut_coefs(), K_BOX);
    check("back2back_pend", 72'(pending_o), 72'(1));
    do_boundary();
    check("emboss", dut_coefs(), K_EMBOSS);
    step();

    // Reset while armed.
    do_sel(3'd2);
    #2 rst_ni = 0;
    #1 model_reset();
    check_all();
    check("arm_rst", dut_coefs(), K_IDENT);
    #1 rst_ni = 1;
    do_boundary();
    check("arm_rst_id", 72'(kernel_id_o), 72'(0));

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      sel_valid_i    = ($urandom_range(0, 15) == 0);
      sel_idx_i      = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 5) == 0) key_next_i = ~key_next_i;
      cfg_wr_valid_i = 1'($urandom_range(0, 1));
      cfg_wr_data_i  = 8'($urandom);
      cfg_commit_i   = ($urandom_range(0, 5) == 0);
      sop_in_i       = ($urandom_range(0, 7) == 0);
      valid_in_i     = ($urandom_range(0, 3) != 0);
      ready_in_i     = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
